// File: rtl/branch_sequencer_if.sv
// Fetch, execute and link handshake between the sequencer (master) and memory/datapath (slave).
// Pure wiring; it adds no latency and no flow control of its own.
interface branch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic              fetch_ack;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] imm;
  logic [31:0]       rs_val;
  logic              alu_carry;
  logic              carry_we;
  logic              exec_done;
  logic              link_we;
  logic [ADDR_W-1:0] link_data;
  logic              taken;

  modport master (
    output fetch_req, link_we, link_data, taken,
    input  fetch_ack, opcode, imm, rs_val, alu_carry, carry_we, exec_done
  );

  modport slave (
    input  fetch_req, link_we, link_data, taken,
    output fetch_ack, opcode, imm, rs_val, alu_carry, carry_we, exec_done
  );
endinterface

// File: rtl/branch_sequencer.sv
// KGP-RISC fetch/execute sequencer: owns PC and carry, resolves branches; branch PC lands 2 cycles after fetch_ack.
// Backpressure: waits in FETCH for fetch_ack (only while i_run) and in EXEC for exec_done on non-branch ops.
module branch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 4,
  parameter int                CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  branch_sequencer_if.master  bus,
  output logic [ADDR_W-1:0]   o_pc,
  output logic [CNT_W-1:0]    o_taken_cnt,
  output logic [1:0]          o_state
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  localparam logic [5:0] OP_BR   = 6'b100000;
  localparam logic [5:0] OP_B    = 6'b101000;
  localparam logic [5:0] OP_BCY  = 6'b101001;
  localparam logic [5:0] OP_BNCY = 6'b101010;
  localparam logic [5:0] OP_BL   = 6'b101011;
  localparam logic [5:0] OP_BLTZ = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;

  localparam logic [ADDR_W-1:0] LP_INC = ADDR_W'(PC_INC);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_carry;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        r_opcode;
  logic [ADDR_W-1:0] r_imm;
  logic              r_take;
  logic [ADDR_W-1:0] r_target;

  logic              w_is_branch;
  logic              w_cond;
  logic [ADDR_W-1:0] w_tgt_raw;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_in_exec;

  always_comb begin
    w_is_branch = 1'b1;
    w_cond      = 1'b0;
    case (r_opcode)
      OP_B, OP_BL, OP_BR: w_cond = 1'b1;
      OP_BCY:             w_cond = r_carry;
      OP_BNCY:            w_cond = ~r_carry;
      OP_BLTZ:            w_cond = bus.rs_val[31];
      OP_BZ:              w_cond = (bus.rs_val == 32'd0);
      OP_BNZ:             w_cond = (bus.rs_val != 32'd0);
      default:            w_is_branch = 1'b0;
    endcase
  end

  assign w_tgt_raw = (r_opcode == OP_BR) ? ADDR_W'(bus.rs_val) : r_imm;
  assign w_target  = {w_tgt_raw[ADDR_W-1:2], 2'b00};
  assign w_pc_inc  = r_pc + LP_INC;
  assign w_in_exec = (r_state == S_EXEC);

  assign bus.fetch_req = (r_state == S_FETCH) && i_run;
  assign bus.link_we   = w_in_exec && (r_opcode == OP_BL);
  assign bus.link_data = w_pc_inc;
  assign bus.taken     = w_in_exec && w_is_branch && w_cond;

  assign o_pc        = r_pc;
  assign o_taken_cnt = r_cnt;
  assign o_state     = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_imm    <= '0;
      r_take   <= 1'b0;
      r_target <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_run && bus.fetch_ack) begin
            r_opcode <= bus.opcode;
            r_imm    <= bus.imm;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Branches resolve in one cycle; carry_we is only honoured for datapath ops.
          if (w_is_branch) begin
            r_take   <= w_cond;
            r_target <= w_target;
            if (w_cond && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            r_state  <= S_UPDATE;
          end else begin
            r_take <= 1'b0;
            if (bus.carry_we) r_carry <= bus.alu_carry;
            if (bus.exec_done) r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_pc    <= r_take ? r_target : w_pc_inc;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed plus random instruction stream against a transaction-level PC/carry/counter model.
// A second instance with a 2-bit counter shares all stimulus so counter saturation is reachable.
module tb_branch_sequencer;

  localparam logic [5:0] OP_BR   = 6'b100000;
  localparam logic [5:0] OP_B    = 6'b101000;
  localparam logic [5:0] OP_BCY  = 6'b101001;
  localparam logic [5:0] OP_BNCY = 6'b101010;
  localparam logic [5:0] OP_BL   = 6'b101011;
  localparam logic [5:0] OP_BLTZ = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;
  localparam logic [5:0] OP_ALU  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] pc, pc2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [1:0]  state, state2;

  always #5 clk = ~clk;

  branch_sequencer_if #(.ADDR_W(32)) bus ();
  branch_sequencer_if #(.ADDR_W(32)) bus2 ();

  assign bus2.fetch_ack = bus.fetch_ack;
  assign bus2.opcode    = bus.opcode;
  assign bus2.imm       = bus.imm;
  assign bus2.rs_val    = bus.rs_val;
  assign bus2.alu_carry = bus.alu_carry;
  assign bus2.carry_we  = bus.carry_we;
  assign bus2.exec_done = bus.exec_done;

  branch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .bus(bus.master),
    .o_pc(pc), .o_taken_cnt(cnt), .o_state(state)
  );

  branch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .bus(bus2.master),
    .o_pc(pc2), .o_taken_cnt(cnt2), .o_state(state2)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] m_pc;
  bit          m_carry;
  int          m_taken_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_branch(input logic [5:0] op);
    return op inside {OP_B, OP_BR, OP_BL, OP_BCY, OP_BNCY, OP_BLTZ, OP_BZ, OP_BNZ};
  endfunction

  function automatic bit branch_taken(input logic [5:0] op, input logic [31:0] rs, input bit c);
    case (op)
      OP_B, OP_BL, OP_BR: return 1'b1;
      OP_BCY:             return c;
      OP_BNCY:            return !c;
      OP_BLTZ:            return rs[31];
      OP_BZ:              return rs == 32'd0;
      OP_BNZ:             return rs != 32'd0;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] exp_cnt(input int limit);
    return 64'((m_taken_total > limit) ? limit : m_taken_total);
  endfunction

  task automatic check_fetch_view();
    chk("pc", pc, m_pc);
    chk("pc_small_cnt_inst", pc2, m_pc);
    chk("taken_cnt", cnt, exp_cnt(65535));
    chk("taken_cnt_sat", cnt2, exp_cnt(3));
  endtask

  // One instruction: FETCH (ack), EXEC (+dly extra cycles for non-branch), UPDATE.
  task automatic do_instr(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] rs,
                          input bit cwe, input bit ac, input int dly);
    bit          br, tk;
    logic [31:0] tgt, nxt;
    br  = is_branch(op);
    tk  = br && branch_taken(op, rs, m_carry);
    tgt = (op == OP_BR) ? rs : imm;
    tgt[1:0] = 2'b00;
    nxt = tk ? tgt : m_pc + 32'd4;

    @(negedge clk);
    bus.fetch_ack = 1'b1;
    bus.opcode    = op;
    bus.imm       = imm;
    bus.rs_val    = rs;
    #1;
    chk("fetch_state", state, 2'd0);
    chk("fetch_req", bus.fetch_req, 1'b1);
    check_fetch_view();

    @(negedge clk);
    bus.fetch_ack = 1'b0;
    bus.carry_we  = cwe;
    bus.alu_carry = ac;
    bus.exec_done = !br && (dly == 0);
    #1;
    chk("exec_state", state, 2'd1);
    chk("taken", bus.taken, tk);
    chk("taken_small_cnt_inst", bus2.taken, tk);
    chk("link_we", bus.link_we, op == OP_BL);
    if (op == OP_BL) chk("link_data", bus.link_data, m_pc + 32'd4);

    if (!br) begin
      for (int i = 1; i <= dly; i++) begin
        @(negedge clk);
        bus.exec_done = (i == dly);
        #1;
        chk("exec_wait_state", state, 2'd1);
        chk("exec_wait_taken", bus.taken, 1'b0);
      end
    end

    @(negedge clk);
    bus.exec_done = 1'b0;
    bus.carry_we  = 1'b0;
    #1;
    chk("update_state", state, 2'd2);
    chk("update_taken", bus.taken, 1'b0);
    chk("update_link_we", bus.link_we, 1'b0);
    chk("update_pc_hold", pc, m_pc);

    if (!br && cwe) m_carry = ac;
    if (tk) m_taken_total++;
    m_pc = nxt;
  endtask

  logic [5:0] ops [12] = '{OP_B, OP_BR, OP_BL, OP_BCY, OP_BNCY, OP_BLTZ, OP_BZ, OP_BNZ,
                           OP_ALU, 6'b000001, 6'b111111, 6'b100001};

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    bus.fetch_ack = 1'b0;
    bus.opcode    = '0;
    bus.imm       = '0;
    bus.rs_val    = '0;
    bus.alu_carry = 1'b0;
    bus.carry_we  = 1'b0;
    bus.exec_done = 1'b0;
    m_pc = 32'h0;
    m_carry = 1'b0;
    m_taken_total = 0;

    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", state, 2'd0);
    chk("rst_taken", bus.taken, 1'b0);
    chk("rst_link_we", bus.link_we, 1'b0);
    chk("rst_fetch_req", bus.fetch_req, 1'b0);
    chk("rst_cnt", cnt, 16'h0);

    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

    do_instr(OP_B, 32'h100, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_B, 32'h40, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_BL, 32'h200, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_ALU, 32'h0, 32'h0, 1'b1, 1'b1, 3);
    do_instr(OP_BCY, 32'h80, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_BNCY, 32'h300, 32'h0, 1'b1, 1'b0, 0);
    do_instr(OP_BZ, 32'h500, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_BNZ, 32'h600, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_BLTZ, 32'h700, 32'h8000_0000, 1'b0, 1'b0, 0);
    do_instr(OP_BR, 32'h0, 32'h123, 1'b0, 1'b0, 0);
    do_instr(OP_B, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_ALU, 32'h0, 32'h0, 1'b1, 1'b0, 1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] rs;
      int          sel;
      sel = $urandom_range(0, 3);
      rs  = $urandom;
      if (sel == 0) rs = 32'h0;
      else if (sel == 1) rs[31] = 1'b1;
      do_instr(ops[$urandom_range(0, 11)], $urandom, rs, 1'($urandom), 1'($urandom),
               $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    check_fetch_view();

    // Reset in the EXEC cycle of a bl.
    @(negedge clk);
    bus.fetch_ack = 1'b1;
    bus.opcode    = OP_BL;
    bus.imm       = 32'h900;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    #1;
    chk("mid_exec_state", state, 2'd1);
    chk("mid_link_we", bus.link_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0;
    m_carry = 1'b0;
    m_taken_total = 0;
    chk("arst_pc", pc, 32'h0);
    chk("arst_state", state, 2'd0);
    chk("arst_link_we", bus.link_we, 1'b0);
    chk("arst_taken", bus.taken, 1'b0);
    chk("arst_cnt", cnt, 16'h0);
    chk("arst_cnt_small", cnt2, 2'd0);
    @(negedge clk);
    #1;
    chk("arst_hold_link_we", bus.link_we, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
    bus.fetch_ack = 1'b1;
    bus.opcode    = OP_B;
    bus.imm       = 32'h44;
    #1;
    chk("idle_fetch_req", bus.fetch_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_state", state, 2'd0);
      chk("idle_pc", pc, 32'h0);
      chk("idle_fetch_req", bus.fetch_req, 1'b0);
    end
    bus.fetch_ack = 1'b0;
    run = 1'b1;

    do_instr(OP_B, 32'h44, 32'h0, 1'b0, 1'b0, 0);
    do_instr(OP_BCY, 32'h88, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    check_fetch_view();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

endmodule
